// File: rtl/ctrl_mc_lsu.sv
// Multicycle fetch/execute/load-store control FSM with sticky illegal/misaligned traps.
// Optional bus watchdog enabled by defining CTRL_BUS_TIMEOUT_EN.
module ctrl_mc_lsu #(
  parameter  int unsigned XLEN           = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned BE_W           = XLEN / 8,
  localparam int unsigned AL_W           = $clog2(XLEN / 8)
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [AL_W-1:0] addr_lsb,
  output logic            instr_req,
  input  logic            instr_gnt,
  input  logic            instr_r_valid,
  output logic            ir_load,
  output logic            data_req,
  input  logic            data_gnt,
  input  logic            data_r_valid,
  output logic            data_write_enable,
  output logic [BE_W-1:0] data_be,
  output logic [2:0]      load_ext,
  output logic            pc_en,
  output logic            MODE,
  output logic            write_enable,
  output logic            ALUSrcMux1,
  output logic            ALUSrcMux1_5,
  output logic            ALUSrcMux2,
  output logic            ALUSrcMux2_S,
  output logic [1:0]      ALUOp,
  output logic            reg_pc_select,
  output logic            alu_dm_select,
  output logic            illegal_instr,
  output logic            misaligned,
  output logic            bus_timeout
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_IWAIT = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DREQ  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;
  localparam logic [2:0] S_TRAP  = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [2:0]      r_load_ext;
  logic [BE_W-1:0] r_be;
  logic            r_store;
  logic            r_load;
  logic            r_illegal;
  logic            r_misaligned;
  logic            w_set_illegal;
  logic            w_set_misaligned;
  logic            w_latch_ls;
  logic            w_timeout;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_ls_illegal;
  logic            w_misalign;
  logic [BE_W-1:0] w_be;

  // Load/store size decode: legality, alignment and byte-enable pattern.
  always_comb begin
    w_is_load    = (opcode == OPC_LOAD);
    w_is_store   = (opcode == OPC_STORE);
    w_ls_illegal = ((funct3[1:0] == 2'b11) && (XLEN == 32)) ||
                   (w_is_load && (funct3 == 3'b111));
    w_misalign   = 1'b0;
    w_be         = '0;
    case (funct3[1:0])
      2'b00: w_be = BE_W'(1) << addr_lsb;
      2'b01: begin
        w_misalign = addr_lsb[0];
        w_be       = BE_W'(2'b11) << addr_lsb;
      end
      2'b10: begin
        w_misalign = (addr_lsb[1:0] != 2'b00);
        w_be       = BE_W'(4'hF) << addr_lsb;
      end
      default: begin
        w_misalign = (addr_lsb != '0);
        w_be       = '1;
      end
    endcase
  end

  // Next state and combinational controls; everything stays 0 while RES is high.
  always_comb begin
    w_next            = r_state;
    w_set_illegal     = 1'b0;
    w_set_misaligned  = 1'b0;
    w_latch_ls        = 1'b0;
    instr_req         = 1'b0;
    ir_load           = 1'b0;
    data_req          = 1'b0;
    data_write_enable = 1'b0;
    data_be           = '0;
    pc_en             = 1'b0;
    MODE              = 1'b0;
    write_enable      = 1'b0;
    ALUSrcMux1        = 1'b0;
    ALUSrcMux1_5      = 1'b0;
    ALUSrcMux2        = 1'b0;
    ALUSrcMux2_S      = 1'b0;
    ALUOp             = 2'b00;
    reg_pc_select     = 1'b0;
    alu_dm_select     = 1'b0;
    if (!RES) begin
      case (r_state)
        S_FETCH: begin
          instr_req = 1'b1;
          if (instr_gnt) w_next = S_IWAIT;
        end
        S_IWAIT: begin
          if (instr_r_valid) begin
            ir_load = 1'b1;
            w_next  = S_EXEC;
          end
        end
        S_EXEC: begin
          w_next = S_FETCH;
          case (opcode)
            OPC_LUI: begin
              ALUSrcMux1_5 = 1'b1;
              ALUSrcMux2   = 1'b1;
              ALUOp        = 2'b10;
              write_enable = 1'b1;
              pc_en        = 1'b1;
            end
            OPC_AUIPC: begin
              ALUSrcMux1   = 1'b1;
              ALUSrcMux2   = 1'b1;
              ALUOp        = 2'b10;
              write_enable = 1'b1;
              pc_en        = 1'b1;
            end
            OPC_OPIMM: begin
              ALUSrcMux2   = 1'b1;
              write_enable = 1'b1;
              pc_en        = 1'b1;
            end
            OPC_OP: begin
              ALUOp        = 2'b01;
              write_enable = 1'b1;
              pc_en        = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
              ALUSrcMux1    = 1'b1;
              ALUSrcMux2_S  = 1'b1;
              ALUOp         = 2'b11;
              reg_pc_select = (opcode == OPC_JALR);
              write_enable  = 1'b1;
              pc_en         = 1'b1;
              MODE          = 1'b1;
            end
            OPC_BRANCH: begin
              ALUOp = 2'b11;
              pc_en = 1'b1;
              MODE  = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
              ALUSrcMux2 = 1'b1;
              w_latch_ls = 1'b1;
              if (w_ls_illegal) begin
                w_set_illegal = 1'b1;
                w_next        = S_TRAP;
              end else if (w_misalign) begin
                w_set_misaligned = 1'b1;
                w_next           = S_TRAP;
              end else begin
                w_next = S_DREQ;
              end
            end
            default: begin
              w_set_illegal = 1'b1;
              w_next        = S_TRAP;
            end
          endcase
        end
        S_DREQ: begin
          data_req          = 1'b1;
          data_write_enable = r_store;
          data_be           = r_be;
          ALUSrcMux2        = 1'b1;
          if (data_gnt) w_next = S_DWAIT;
        end
        S_DWAIT: begin
          if (data_r_valid) begin
            pc_en         = 1'b1;
            write_enable  = r_load;
            alu_dm_select = r_load;
            w_next        = S_FETCH;
          end
        end
        S_TRAP:  w_next = S_TRAP;
        default: w_next = S_FETCH;
      endcase
      if (w_timeout) w_next = S_TRAP;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state      <= S_FETCH;
      r_load_ext   <= 3'b000;
      r_be         <= '0;
      r_store      <= 1'b0;
      r_load       <= 1'b0;
      r_illegal    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch_ls) begin
        r_load_ext <= funct3;
        r_be       <= w_be;
        r_store    <= w_is_store;
        r_load     <= w_is_load;
      end
      if (w_set_illegal)    r_illegal    <= 1'b1;
      if (w_set_misaligned) r_misaligned <= 1'b1;
    end
  end

`ifdef CTRL_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_timeout;
  logic             w_bus_state;

  assign w_bus_state = (r_state == S_FETCH) || (r_state == S_IWAIT) ||
                       (r_state == S_DREQ)  || (r_state == S_DWAIT);
  assign w_timeout   = w_bus_state && (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Wait-cycle counter restarts on every state change.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_cnt         <= '0;
      r_bus_timeout <= 1'b0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else if (w_bus_state)  r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout) r_bus_timeout <= 1'b1;
    end
  end

  assign bus_timeout = r_bus_timeout;
`else
  assign w_timeout   = 1'b0;
  assign bus_timeout = 1'b0;
`endif

  assign load_ext      = r_load_ext;
  assign illegal_instr = r_illegal;
  assign misaligned    = r_misaligned;

endmodule

// File: tb/tb_ctrl_mc_lsu.sv
// Directed bench for ctrl_mc_lsu: ALU/jump/branch, LW/SB with bus stalls, traps and reset recovery.
module tb_ctrl_mc_lsu;

  logic       CLK = 1'b0;
  logic       RES = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [1:0] addr_lsb = '0;
  logic       instr_gnt = 1'b0, instr_r_valid = 1'b0;
  logic       data_gnt = 1'b0, data_r_valid = 1'b0;
  logic       instr_req, ir_load, data_req, data_write_enable;
  logic [3:0] data_be;
  logic [2:0] load_ext;
  logic       pc_en, MODE, write_enable;
  logic       ALUSrcMux1, ALUSrcMux1_5, ALUSrcMux2, ALUSrcMux2_S;
  logic [1:0] ALUOp;
  logic       reg_pc_select, alu_dm_select;
  logic       illegal_instr, misaligned, bus_timeout;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ctrl_mc_lsu #(.XLEN(32), .TIMEOUT_CYCLES(255)) u_dut (
    .CLK(CLK), .RES(RES), .opcode(opcode), .funct3(funct3), .addr_lsb(addr_lsb),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_r_valid(instr_r_valid),
    .ir_load(ir_load), .data_req(data_req), .data_gnt(data_gnt), .data_r_valid(data_r_valid),
    .data_write_enable(data_write_enable), .data_be(data_be), .load_ext(load_ext),
    .pc_en(pc_en), .MODE(MODE), .write_enable(write_enable),
    .ALUSrcMux1(ALUSrcMux1), .ALUSrcMux1_5(ALUSrcMux1_5), .ALUSrcMux2(ALUSrcMux2),
    .ALUSrcMux2_S(ALUSrcMux2_S), .ALUOp(ALUOp), .reg_pc_select(reg_pc_select),
    .alu_dm_select(alu_dm_select), .illegal_instr(illegal_instr), .misaligned(misaligned),
    .bus_timeout(bus_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge CLK);
  endtask

  // Entered at a negedge in S_FETCH; returns just after the negedge of S_EXEC.
  task automatic do_fetch(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] al);
    opcode   = op;
    funct3   = f3;
    addr_lsb = al;
    #1;
    chk("fetch_ireq", 32'(instr_req), 32'd1);
    instr_gnt = 1'b1;
    nxt();
    instr_gnt     = 1'b0;
    instr_r_valid = 1'b1;
    #1;
    chk("iwait_ireq", 32'(instr_req), 32'd0);
    chk("iwait_irload", 32'(ir_load), 32'd1);
    nxt();
    instr_r_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_reset();
    RES = 1'b1;
    instr_gnt = 1'b0; instr_r_valid = 1'b0; data_gnt = 1'b0; data_r_valid = 1'b0;
    nxt();
    RES = 1'b0;
  endtask

  initial begin
    #2 RES = 1'b1;
    nxt(); nxt();
    #1;
    chk("rst_ireq", 32'(instr_req), 32'd0);
    chk("rst_dreq", 32'(data_req), 32'd0);
    chk("rst_illegal", 32'(illegal_instr), 32'd0);
    chk("rst_misal", 32'(misaligned), 32'd0);
    chk("rst_tmo", 32'(bus_timeout), 32'd0);
    chk("rst_ldext", 32'(load_ext), 32'd0);
    nxt();
    RES = 1'b0;

    // ADDI x1, x0, imm
    do_fetch(7'b0010011, 3'b000, 2'd0);
    chk("addi_we", 32'(write_enable), 32'd1);
    chk("addi_pcen", 32'(pc_en), 32'd1);
    chk("addi_aluop", 32'(ALUOp), 32'd0);
    chk("addi_src2", 32'(ALUSrcMux2), 32'd1);
    chk("addi_mode", 32'(MODE), 32'd0);
    nxt(); #1;
    chk("addi_back", 32'(instr_req), 32'd1);

    // JAL
    do_fetch(7'b1101111, 3'b000, 2'd0);
    chk("jal_mode", 32'(MODE), 32'd1);
    chk("jal_aluop", 32'(ALUOp), 32'd3);
    chk("jal_we", 32'(write_enable), 32'd1);
    chk("jal_pcen", 32'(pc_en), 32'd1);
    nxt();

    // BRANCH
    do_fetch(7'b1100011, 3'b000, 2'd0);
    chk("br_we", 32'(write_enable), 32'd0);
    chk("br_mode", 32'(MODE), 32'd1);
    chk("br_pcen", 32'(pc_en), 32'd1);
    nxt();

    // LW addr_lsb=0, gnt after 3 stall cycles
    do_fetch(7'b0000011, 3'b010, 2'd0);
    chk("lw_src2", 32'(ALUSrcMux2), 32'd1);
    chk("lw_aluop", 32'(ALUOp), 32'd0);
    chk("lw_exec_dreq", 32'(data_req), 32'd0);
    chk("lw_exec_we", 32'(write_enable), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("lw_stall_dreq", 32'(data_req), 32'd1);
      chk("lw_stall_be", 32'(data_be), 32'hF);
      chk("lw_stall_dwe", 32'(data_write_enable), 32'd0);
    end
    nxt();
    data_gnt = 1'b1;
    #1;
    chk("lw_gnt_dreq", 32'(data_req), 32'd1);
    chk("lw_ldext", 32'(load_ext), 32'd2);
    nxt();
    data_gnt     = 1'b0;
    data_r_valid = 1'b1;
    #1;
    chk("lw_dwait_dreq", 32'(data_req), 32'd0);
    chk("lw_we", 32'(write_enable), 32'd1);
    chk("lw_dmsel", 32'(alu_dm_select), 32'd1);
    chk("lw_pcen", 32'(pc_en), 32'd1);
    nxt();
    data_r_valid = 1'b0;
    #1;
    chk("lw_back", 32'(instr_req), 32'd1);

    // SB addr_lsb=2, early r_valid in S_DREQ must be ignored
    do_fetch(7'b0100011, 3'b000, 2'd2);
    chk("sb_exec_we", 32'(write_enable), 32'd0);
    nxt();
    data_r_valid = 1'b1;
    #1;
    chk("sb_dreq", 32'(data_req), 32'd1);
    chk("sb_dwe", 32'(data_write_enable), 32'd1);
    chk("sb_be", 32'(data_be), 32'h4);
    nxt();
    data_r_valid = 1'b0;
    data_gnt     = 1'b1;
    #1;
    chk("sb_still_dreq", 32'(data_req), 32'd1);
    nxt();
    data_gnt     = 1'b0;
    data_r_valid = 1'b1;
    #1;
    chk("sb_pcen", 32'(pc_en), 32'd1);
    chk("sb_we", 32'(write_enable), 32'd0);
    chk("sb_dmsel", 32'(alu_dm_select), 32'd0);
    nxt();
    data_r_valid = 1'b0;
    #1;
    chk("sb_back", 32'(instr_req), 32'd1);

    // Long instruction-bus stall: default build waits forever
    repeat (20) nxt();
    #1;
    chk("stall_ireq", 32'(instr_req), 32'd1);
    chk("stall_tmo", 32'(bus_timeout), 32'd0);

    // LH addr_lsb=1 -> misaligned trap, frozen until RES
    do_fetch(7'b0000011, 3'b001, 2'd1);
    chk("lh_exec_dreq", 32'(data_req), 32'd0);
    nxt();
    instr_gnt = 1'b1; instr_r_valid = 1'b1; data_gnt = 1'b1; data_r_valid = 1'b1;
    #1;
    chk("lh_misal", 32'(misaligned), 32'd1);
    chk("lh_illegal", 32'(illegal_instr), 32'd0);
    chk("lh_trap_ireq", 32'(instr_req), 32'd0);
    chk("lh_trap_dreq", 32'(data_req), 32'd0);
    chk("lh_trap_pcen", 32'(pc_en), 32'd0);
    repeat (5) nxt();
    #1;
    chk("lh_frz_ireq", 32'(instr_req), 32'd0);
    chk("lh_frz_irload", 32'(ir_load), 32'd0);
    chk("lh_frz_we", 32'(write_enable), 32'd0);
    chk("lh_frz_misal", 32'(misaligned), 32'd1);
    RES = 1'b1;
    instr_gnt = 1'b0; instr_r_valid = 1'b0; data_gnt = 1'b0; data_r_valid = 1'b0;
    #1;
    chk("lh_rst_misal", 32'(misaligned), 32'd0);
    chk("lh_rst_ireq", 32'(instr_req), 32'd0);
    nxt();
    RES = 1'b0;
    #1;
    chk("lh_rel_ireq", 32'(instr_req), 32'd1);

    // Opcode 7F -> illegal
    do_fetch(7'h7F, 3'b000, 2'd0);
    chk("ill_we", 32'(write_enable), 32'd0);
    chk("ill_pcen", 32'(pc_en), 32'd0);
    nxt(); #1;
    chk("ill_flag", 32'(illegal_instr), 32'd1);
    chk("ill_misal", 32'(misaligned), 32'd0);
    chk("ill_ireq", 32'(instr_req), 32'd0);
    pulse_reset();

    // LD (funct3=011) is illegal for XLEN=32
    do_fetch(7'b0000011, 3'b011, 2'd0);
    nxt(); #1;
    chk("ld32_illegal", 32'(illegal_instr), 32'd1);
    chk("ld32_dreq", 32'(data_req), 32'd0);
    pulse_reset();

    // RES pulse during S_DWAIT, stale r_valid afterwards ignored
    do_fetch(7'b0000011, 3'b010, 2'd0);
    nxt();
    data_gnt = 1'b1;
    nxt();
    data_gnt = 1'b0;
    #1;
    chk("dw_dreq", 32'(data_req), 32'd0);
    chk("dw_we", 32'(write_enable), 32'd0);
    RES = 1'b1;
    #1;
    chk("dw_rst_ireq", 32'(instr_req), 32'd0);
    chk("dw_rst_ldext", 32'(load_ext), 32'd0);
    chk("dw_rst_illegal", 32'(illegal_instr), 32'd0);
    nxt();
    RES = 1'b0;
    data_r_valid = 1'b1;
    #1;
    chk("dw_rel_ireq", 32'(instr_req), 32'd1);
    chk("dw_rel_we", 32'(write_enable), 32'd0);
    chk("dw_rel_pcen", 32'(pc_en), 32'd0);
    nxt();
    data_r_valid = 1'b0;
    #1;
    chk("dw_hold_ireq", 32'(instr_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
